wb_stream_writer_sched: RTL and testbench
=========================================

// Module: wb_stream_writer_sched
// PURPOSE
//  Descriptor-queue scheduler for the stream writer DMA. Software pushes (start_adr, buf_size)
//  descriptors over a Wishbone slave port. The block then launches the writer once per descriptor
//  and waits for each buffer to complete before launching the next, so several buffers stream
//  back-to-back without CPU intervention. Sits between the CPU bus and the writer's
//  enable/start_adr/buf_size/burst_size/busy interface.
// PARAMETERS
//  WB_AW       32  Wishbone address width; also width of start_adr/buf_size/burst_size
//  WB_DW       32  Wishbone data width (must be 32)
//  DEPTH_LOG2  2   log2 of descriptor FIFO depth (4 entries)
//  START_TO    16  cycles to wait for busy to rise after enable before flagging a start error
// PORTS
//  wb_clk_i    in   1            clock
//  wb_rst_ni   in   1            asynchronous active-low reset
//  wb_adr_i    in   WB_AW        byte address; only [4:2] decoded
//  wb_dat_i    in   WB_DW        write data
//  wb_sel_i    in   WB_DW/8      byte selects (ignored; full-word access only)
//  wb_we_i     in   1            write enable
//  wb_cyc_i    in   1            cycle
//  wb_stb_i    in   1            strobe
//  wb_cti_i    in   3            ignored
//  wb_bte_i    in   2            ignored
//  wb_dat_o    out  WB_DW        read data, combinational from wb_adr_i
//  wb_ack_o    out  1            ack
//  wb_err_o    out  1            tied 0
//  wb_rty_o    out  1            tied 0
//  irq         out  1            level interrupt, set on buffer done or error, cleared by software
//  busy        in   1            writer busy
//  enable      out  1            one-cycle launch pulse to writer
//  start_adr   out  WB_AW        head descriptor address, held stable while launched
//  buf_size    out  WB_AW        head descriptor size, held stable while launched
//  burst_size  out  WB_AW        burst length register
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; FIFO empty; FSM IDLE; all regs/counters 0.
//  Bus: ack rises the cycle after cyc&stb&!ack and is held 1 cycle; back-to-back access gives
//   ack every other cycle. Writes commit on the ack cycle.
//  Register map (adr[4:2]):
//   0 CTRL  W: b0 run, b1 clear irq (W1C), b2 flush FIFO (ignored unless FSM IDLE), b3 clear err/ovf.
//           R: {fill[DEPTH_LOG2:0] at [15:8], ovf[6], err[5], full[4], empty[3], irq[2], busy[1], run[0]}.
//   1 DADR  W: stage descriptor address. R: staged value.
//   2 DSIZE W: push {DADR, wdata} into FIFO. If full: descriptor dropped, ovf sticky set. R: 0.
//   3 BURST R/W: burst_size.
//   4 DONE  R: completed-buffer count, wraps at 2^WB_DW. W: ignored.
//   Others: read 0, write ignored.
//  FSM:
//   IDLE -> LAUNCH when run & !empty & !busy.
//   LAUNCH: enable=1 for exactly 1 cycle; start_adr/buf_size loaded from FIFO head on entry. -> WAIT_S.
//   WAIT_S: busy=1 -> WAIT_E. START_TO cycles without busy -> ERR.
//   WAIT_E: busy falling (busy=0, prev busy=1) -> DONE.
//   DONE: pop head; DONE+=1; irq<=1 -> IDLE.
//   ERR: pop head; err<=1; irq<=1; run<=0 -> IDLE.
//  start_adr/buf_size hold their last values in IDLE.
//  Clearing run mid-buffer does not abort; the current buffer completes, then the FSM stays IDLE.
//  Same-cycle push and pop: both take effect and fill is unchanged. Push when full and pop in the
//   same cycle is still treated as full (dropped).
//  Same-cycle irq set and software clear: set wins.
//  Reset mid-buffer: FSM returns to IDLE and queued descriptors are lost.
// TESTING
//  1. Reset, read CTRL -> 0x08 (empty); all outputs 0.
//  2. Push (0x1000,64),(0x2000,32); BURST=8; CTRL=1; writer model holds busy 10 cycles ->
//     enable pulses twice with start_adr 0x1000 then 0x2000; DONE=2; irq=1; empty.
//  3. Push 5 descriptors with DEPTH_LOG2=2 -> fill=4, ovf=1, 5th never launched.
//  4. Writer model never asserts busy -> enable pulse, 16 cycles later err=1, irq=1, run=0,
//     descriptor popped.
//  5. Clear run while in WAIT_E with 2 descriptors queued -> current completes (DONE+1), no
//     further enable; set run -> next launches.
//  6. Assert wb_rst_ni low mid WAIT_E -> enable/irq/FIFO reset immediately; CTRL reads 0x08
//     after release.

Source files
------------

// File: rtl/wb_stream_writer_sched.sv
// wb_stream_writer_sched
//   Descriptor-queue scheduler for the stream writer DMA. Software pushes
//   (start_adr, buf_size) descriptors through a Wishbone slave port. The block
//   launches the writer once per queued descriptor and waits for each buffer to
//   finish before launching the next one.
// Ports
//   wb_clk_i, wb_rst_ni       clock, async active-low reset (release synchronised)
//   wb_*                      Wishbone slave; regs decoded on wb_adr_i[4:2]
//   irq                       level interrupt: buffer done or start error
//   busy                      writer busy (input)
//   enable                    one-cycle launch pulse to the writer
//   start_adr/buf_size        head descriptor, held while launched and in IDLE
//   burst_size                burst length register
module wb_stream_writer_sched #(
  parameter int WB_AW      = 32,
  parameter int WB_DW      = 32,
  parameter int DEPTH_LOG2 = 2,
  parameter int START_TO   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [WB_DW/8-1:0] wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic               irq,
  input  logic               busy,
  output logic               enable,
  output logic [WB_AW-1:0]   start_adr,
  output logic [WB_AW-1:0]   buf_size,
  output logic [WB_AW-1:0]   burst_size
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(START_TO + 1);

  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [WB_AW-1:0] size;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_S, S_WAIT_E, S_DONE, S_ERR
  } state_t;

  // Reset asserts asynchronously, releases two clocks later in this domain.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  logic unused_in;
  assign unused_in = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[WB_AW-1:5], wb_adr_i[1:0]};

  // ---------------- bus ----------------
  logic       acc, wr;
  logic [2:0] rsel;
  logic       wr_ctrl, wr_dadr, wr_dsize, wr_burst;

  assign acc      = wb_cyc_i & wb_stb_i;
  assign rsel     = wb_adr_i[4:2];
  // writes commit on the ack cycle while the master still holds the request
  assign wr       = wb_ack_o & acc & wb_we_i;
  assign wr_ctrl  = wr && rsel == 3'd0;
  assign wr_dadr  = wr && rsel == 3'd1;
  assign wr_dsize = wr && rsel == 3'd2;
  assign wr_burst = wr && rsel == 3'd3;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) wb_ack_o <= 1'b0;
    else        wb_ack_o <= acc & ~wb_ack_o;

  // ---------------- state ----------------
  state_t           state, nxt;
  logic             run, err, ovf, busy_q, pop, flush;
  logic [WB_AW-1:0] dadr;
  logic [WB_DW-1:0] done_cnt;
  logic [TW-1:0]    to_cnt;
  desc_t            fifo [DEPTH];
  logic [FW-1:0]    wp, rp, fill;
  logic             empty, full;

  assign fill  = wp - rp;
  assign empty = fill == '0;
  assign full  = fill == FW'(DEPTH);
  // flush only applies while idle; it also blocks a launch in the same cycle so
  // a head already emptied away is never started
  assign flush = wr_ctrl && wb_dat_i[2] && state == S_IDLE;

  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      S_IDLE:   if (run && !empty && !busy && !flush) nxt = S_LAUNCH;
      S_LAUNCH: nxt = S_WAIT_S;
      S_WAIT_S: begin
        if (busy)                              nxt = S_WAIT_E;
        else if (to_cnt == TW'(START_TO - 1))  nxt = S_ERR;
      end
      S_WAIT_E: if (!busy && busy_q) nxt = S_DONE;
      S_DONE:   begin pop = 1'b1; nxt = S_IDLE; end
      S_ERR:    begin pop = 1'b1; nxt = S_IDLE; end
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  assign enable = state == S_LAUNCH;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      to_cnt     <= '0;
      start_adr  <= '0;
      buf_size   <= '0;
      burst_size <= '0;
      dadr       <= '0;
      done_cnt   <= '0;
      run        <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      irq        <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      busy_q <= busy;

      if (state == S_LAUNCH)      to_cnt <= '0;
      else if (state == S_WAIT_S) to_cnt <= to_cnt + 1'b1;

      if (state == S_IDLE && nxt == S_LAUNCH) begin
        start_adr <= fifo[rp[DEPTH_LOG2-1:0]].adr;
        buf_size  <= fifo[rp[DEPTH_LOG2-1:0]].size;
      end

      if (wr_dadr)  dadr       <= WB_AW'(wb_dat_i);
      if (wr_burst) burst_size <= WB_AW'(wb_dat_i);

      // fullness is judged before any same-cycle pop
      if (wr_dsize && !full) begin
        fifo[wp[DEPTH_LOG2-1:0]] <= '{adr: dadr, size: WB_AW'(wb_dat_i)};
        wp <= wp + 1'b1;
      end

      if (pop)        rp <= rp + 1'b1;
      else if (flush) rp <= wp;

      if (state == S_DONE) done_cnt <= done_cnt + 1'b1;

      // hardware set wins over a same-cycle software clear
      if (state == S_DONE || state == S_ERR) irq <= 1'b1;
      else if (wr_ctrl && wb_dat_i[1])       irq <= 1'b0;

      if (state == S_ERR)                    err <= 1'b1;
      else if (wr_ctrl && wb_dat_i[3])       err <= 1'b0;

      if (wr_dsize && full)                  ovf <= 1'b1;
      else if (wr_ctrl && wb_dat_i[3])       ovf <= 1'b0;

      if (state == S_ERR) run <= 1'b0;
      else if (wr_ctrl)   run <= wb_dat_i[0];
    end
  end

  // ---------------- read mux ----------------
  logic [WB_DW-1:0] ctrl_rd;
  always_comb begin
    ctrl_rd         = '0;
    ctrl_rd[0]      = run;
    ctrl_rd[1]      = busy;
    ctrl_rd[2]      = irq;
    ctrl_rd[3]      = empty;
    ctrl_rd[4]      = full;
    ctrl_rd[5]      = err;
    ctrl_rd[6]      = ovf;
    ctrl_rd[8 +: FW] = fill;
  end

  always_comb begin
    wb_dat_o = '0;
    case (rsel)
      3'd0:    wb_dat_o = ctrl_rd;
      3'd1:    wb_dat_o = WB_DW'(dadr);
      3'd3:    wb_dat_o = WB_DW'(burst_size);
      3'd4:    wb_dat_o = done_cnt;
      default: wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_wb_stream_writer_sched.sv
module tb_wb_stream_writer_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr, wb_dat, wb_dat_o;
  logic [3:0]  wb_sel = 4'hf;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
  logic [2:0]  wb_cti = 3'd0;
  logic [1:0]  wb_bte = 2'd0;
  logic        irq, busy, enable;
  logic [31:0] start_adr, buf_size, burst_size;

  int tests = 0, fails = 0;
  int launch_cnt = 0, dbl_en = 0;
  logic [31:0] l_adr [0:31];
  logic [31:0] l_size [0:31];
  logic model_resp = 1'b1;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  wb_stream_writer_sched dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_cti_i(wb_cti), .wb_bte_i(wb_bte), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack),
    .wb_err_o(wb_err), .wb_rty_o(wb_rty), .irq(irq), .busy(busy), .enable(enable),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size)
  );

  // launch recorder
  initial forever begin
    @(posedge clk); #1;
    if (enable) begin
      if (launch_cnt < 32) begin
        l_adr[launch_cnt]  = start_adr;
        l_size[launch_cnt] = buf_size;
      end
      launch_cnt++;
      if (en_prev) dbl_en++;
    end
    en_prev = enable;
  end

  // writer model: busy rises 2 cycles after enable, stays high 10 cycles
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (enable && model_resp) begin
        repeat (2) @(posedge clk);
        #1 busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 busy = 1'b0;
      end
    end
  end

  task automatic wb_xfer(input logic [2:0] r, input logic we, input logic [31:0] d,
                         output logic [31:0] q);
    logic got;
    @(negedge clk);
    wb_adr = {27'd0, r, 2'b00}; wb_we = we; wb_dat = d; wb_cyc = 1'b1; wb_stb = 1'b1;
    q = '0; got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin got = 1'b1; q = wb_dat_o; break; end
    end
    tests++;
    if (!got) begin fails++; $display("FAIL bus_ack reg=%0d got no ack within 8 cycles", r); end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(r, 1'b1, d, q);
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] q);
    wb_xfer(r, 1'b0, 32'd0, q);
  endtask

  task automatic wait_launches(input int n);
    int i;
    for (i = 0; i < 400; i++) begin
      if (launch_cnt >= n) break;
      @(posedge clk); #1;
    end
    if (i == 400) begin
      tests++; fails++;
      $display("FAIL launch_wait got %0d launches required %0d", launch_cnt, n);
    end
  endtask

  task automatic wait_busy();
    int i;
    for (i = 0; i < 100; i++) begin
      if (busy) break;
      @(posedge clk); #1;
    end
    if (i == 100) begin
      tests++; fails++;
      $display("FAIL busy_wait writer busy never rose");
    end
  endtask

  task automatic test_reset();
    logic [31:0] q;
    rst_n = 1'b0; wb_adr = '0; wb_dat = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    tests++;
    if ({enable, irq, wb_ack, wb_err, wb_rty} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b required 00000", {enable, irq, wb_ack, wb_err, wb_rty});
    end
    tests++;
    if ({start_adr, buf_size, burst_size} !== 96'd0) begin
      fails++; $display("FAIL reset_outs got %h %h %h required 0", start_adr, buf_size, burst_size);
    end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h08) begin fails++; $display("FAIL reset_ctrl got %h required 00000008", q); end
    rd(3'd4, q);
    tests++;
    if (q !== 32'h0) begin fails++; $display("FAIL reset_done got %h required 0", q); end
  endtask

  task automatic test_two_buffers();
    logic [31:0] q;
    wr(3'd1, 32'h1000); wr(3'd2, 32'd64);
    wr(3'd1, 32'h2000); wr(3'd2, 32'd32);
    rd(3'd1, q);
    tests++;
    if (q !== 32'h2000) begin fails++; $display("FAIL dadr_rb got %h required 00002000", q); end
    rd(3'd2, q);
    tests++;
    if (q !== 32'h0) begin fails++; $display("FAIL dsize_rb got %h required 0", q); end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h200) begin fails++; $display("FAIL fill2_ctrl got %h required 00000200", q); end
    wr(3'd3, 32'd8);
    rd(3'd3, q);
    tests++;
    if (q !== 32'd8 || burst_size !== 32'd8) begin
      fails++; $display("FAIL burst got rd=%h out=%h required 8", q, burst_size);
    end
    rd(3'd5, q);
    tests++;
    if (q !== 32'h0) begin fails++; $display("FAIL unmapped_rd got %h required 0", q); end
    wr(3'd0, 32'h1);
    wait_launches(2);
    repeat (30) @(posedge clk); #1;
    tests++;
    if (launch_cnt !== 2) begin fails++; $display("FAIL tb2_launches got %0d required 2", launch_cnt); end
    tests++;
    if (l_adr[0] !== 32'h1000 || l_size[0] !== 32'd64) begin
      fails++; $display("FAIL tb2_desc0 got %h/%0d required 1000/64", l_adr[0], l_size[0]);
    end
    tests++;
    if (l_adr[1] !== 32'h2000 || l_size[1] !== 32'd32) begin
      fails++; $display("FAIL tb2_desc1 got %h/%0d required 2000/32", l_adr[1], l_size[1]);
    end
    tests++;
    if (dbl_en !== 0) begin fails++; $display("FAIL enable_width got %0d long pulses required 0", dbl_en); end
    tests++;
    if (start_adr !== 32'h2000) begin fails++; $display("FAIL idle_hold got %h required 00002000", start_adr); end
    rd(3'd4, q);
    tests++;
    if (q !== 32'd2) begin fails++; $display("FAIL tb2_done got %0d required 2", q); end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h0D) begin fails++; $display("FAIL tb2_ctrl got %h required 0000000d", q); end
    wr(3'd0, 32'h3);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b required 0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] q;
    wr(3'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      wr(3'd1, 32'h3000 + 32'(i) * 32'h100);
      wr(3'd2, 32'h10 * 32'(i + 1));
    end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h450) begin fails++; $display("FAIL ovf_ctrl got %h required 00000450", q); end
    wr(3'd0, 32'h9);
    wait_launches(6);
    repeat (60) @(posedge clk); #1;
    tests++;
    if (launch_cnt !== 6) begin fails++; $display("FAIL ovf_launches got %0d required 6", launch_cnt); end
    tests++;
    if (l_adr[5] !== 32'h3300 || l_size[5] !== 32'h40) begin
      fails++; $display("FAIL ovf_last got %h/%h required 3300/40", l_adr[5], l_size[5]);
    end
    rd(3'd4, q);
    tests++;
    if (q !== 32'd6) begin fails++; $display("FAIL ovf_done got %0d required 6", q); end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h0D) begin fails++; $display("FAIL ovf_clr_ctrl got %h required 0000000d", q); end
  endtask

  task automatic test_start_timeout();
    logic [31:0] q;
    int n;
    logic seen;
    wr(3'd0, 32'h2);
    model_resp = 1'b0;
    wr(3'd1, 32'h5000); wr(3'd2, 32'h40);
    wr(3'd0, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (enable) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL to_enable got no launch pulse"); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; n++;
      if (irq) break;
    end
    tests++;
    if (n < 16 || n > 19) begin fails++; $display("FAIL to_delay got %0d cycles required 16..19", n); end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h2C) begin fails++; $display("FAIL to_ctrl got %h required 0000002c", q); end
    tests++;
    if (l_adr[6] !== 32'h5000) begin fails++; $display("FAIL to_adr got %h required 00005000", l_adr[6]); end
    model_resp = 1'b1;
  endtask

  task automatic test_run_clear();
    logic [31:0] q;
    wr(3'd0, 32'hA);
    wr(3'd1, 32'h6000); wr(3'd2, 32'h80);
    wr(3'd1, 32'h7000); wr(3'd2, 32'h90);
    wr(3'd0, 32'h1);
    wait_busy();
    wr(3'd0, 32'h0);
    repeat (60) @(posedge clk); #1;
    tests++;
    if (launch_cnt !== 8) begin fails++; $display("FAIL rc_launches got %0d required 8", launch_cnt); end
    rd(3'd4, q);
    tests++;
    if (q !== 32'd7) begin fails++; $display("FAIL rc_done got %0d required 7", q); end
    rd(3'd0, q);
    tests++;
    if (q !== 32'h104) begin fails++; $display("FAIL rc_ctrl got %h required 00000104", q); end
    wr(3'd0, 32'h1);
    wait_launches(9);
    repeat (40) @(posedge clk); #1;
    tests++;
    if (launch_cnt !== 9 || l_adr[8] !== 32'h7000) begin
      fails++; $display("FAIL rc_resume got %0d/%h required 9/00007000", launch_cnt, l_adr[8]);
    end
    rd(3'd4, q);
    tests++;
    if (q !== 32'd8) begin fails++; $display("FAIL rc_done2 got %0d required 8", q); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    wr(3'd1, 32'h8000); wr(3'd2, 32'h10);
    wr(3'd1, 32'h9000); wr(3'd2, 32'h20);
    wait_busy();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({enable, irq} !== 2'b00) begin fails++; $display("FAIL rm_flags got %b required 00", {enable, irq}); end
    tests++;
    if ({start_adr, buf_size, burst_size} !== 96'd0) begin
      fails++; $display("FAIL rm_outs got %h %h %h required 0", start_adr, buf_size, burst_size);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    rd(3'd0, q);
    tests++;
    if (q !== 32'h08) begin fails++; $display("FAIL rm_ctrl got %h required 00000008", q); end
    rd(3'd4, q);
    tests++;
    if (q !== 32'h0) begin fails++; $display("FAIL rm_done got %h required 0", q); end
    tests++;
    if (launch_cnt !== 10) begin fails++; $display("FAIL rm_launches got %0d required 10", launch_cnt); end
  endtask

  initial begin
    test_reset();
    test_two_buffers();
    test_overflow();
    test_start_timeout();
    test_run_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end
endmodule
